// File: rtl/display_mux_7seg.sv
// Multiplexed 4-digit common-anode 7-segment scanner for an HH:MM clock with frame snapshot,
// dead time, leading-zero blanking, colon and sticky invalid-time flag. Optional macro: DISPLAY_MUX_BLINK_EN.
module display_mux_7seg #(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned DEAD         = 4,
  parameter int unsigned BLINK_FRAMES = 125
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] dhour_i,
  input  logic [3:0] uhour_i,
  input  logic [3:0] dmin_i,
  input  logic [3:0] umin_i,
  input  logic       blank_lz_i,
  output logic [3:0] an_o,
  output logic [6:0] seg_o,
  output logic       dp_o,
  output logic       frame_done_o,
  output logic       err_o
);

  localparam int unsigned DIG_W = 4;
  localparam int unsigned SEG_W = 7;
  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef struct packed {
    logic [DIG_W-1:0] dh;
    logic [DIG_W-1:0] uh;
    logic [DIG_W-1:0] dm;
    logic [DIG_W-1:0] um;
  } digits_t;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  digits_t          shadow_q, shadow_d;
  logic             err_q, err_d;
  logic [3:0]       an_d;
  logic [SEG_W-1:0] seg_d;
  logic             dp_d;
  logic             frame_done_d;
  logic             colon_on;
  logic             frame_end_c;

  function automatic logic [SEG_W-1:0] decode(input logic [DIG_W-1:0] d);
    logic [SEG_W-1:0] s;
    case (d)
      4'd0:    s = 7'b0111111;
      4'd1:    s = 7'b0000110;
      4'd2:    s = 7'b1011011;
      4'd3:    s = 7'b1001111;
      4'd4:    s = 7'b1100110;
      4'd5:    s = 7'b1101101;
      4'd6:    s = 7'b1111101;
      4'd7:    s = 7'b0000111;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1101111;
      default: s = 7'b1000000;
    endcase
    return s;
  endfunction

  // Scan counters, snapshot capture and output pre-computation
  always_comb begin
    logic             slot_end;
    logic             snap;
    logic             dead;
    logic             blank;
    logic             invalid;
    logic [DIG_W-1:0] cur;

    cnt_d        = cnt_q + CNT_W'(1);
    idx_d        = idx_q;
    shadow_d     = shadow_q;
    err_d        = err_q;
    an_d         = 4'b1111;
    seg_d        = '0;
    dp_d         = 1'b0;
    cur          = '0;

    slot_end = (cnt_q == CNT_W'(SCAN_DIV - 1));
    if (slot_end) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end
    frame_end_c  = slot_end && (idx_q == 2'd3);
    frame_done_d = frame_end_c;

    // Whole-time snapshot only at the start of a frame keeps the display tear-free
    snap    = (cnt_q == '0) && (idx_q == 2'd0);
    invalid = (dhour_i > 4'd9) || (uhour_i > 4'd9) || (dmin_i > 4'd9) || (umin_i > 4'd9) ||
              (dhour_i > 4'd2) || ((dhour_i == 4'd2) && (uhour_i > 4'd3)) || (dmin_i > 4'd5);
    if (snap) begin
      shadow_d = '{dh: dhour_i, uh: uhour_i, dm: dmin_i, um: umin_i};
      err_d    = err_q | invalid;
    end

    case (idx_q)
      2'd0:    cur = shadow_q.dh;
      2'd1:    cur = shadow_q.uh;
      2'd2:    cur = shadow_q.dm;
      default: cur = shadow_q.um;
    endcase

    dead  = (cnt_q < CNT_W'(DEAD));
    blank = blank_lz_i && (idx_q == 2'd0) && (shadow_q.dh == '0);
    if (!dead && !blank) begin
      an_d  = ~(4'b1000 >> idx_q);
      seg_d = decode(cur);
    end
    if (!dead && (idx_q == 2'd1)) begin
      dp_d = colon_on;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      shadow_q     <= '0;
      err_q        <= 1'b0;
      an_o         <= 4'b1111;
      seg_o        <= '0;
      dp_o         <= 1'b0;
      frame_done_o <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      err_q        <= err_d;
      an_o         <= an_d;
      seg_o        <= seg_d;
      dp_o         <= dp_d;
      frame_done_o <= frame_done_d;
    end
  end

  assign err_o = err_q;

`ifdef DISPLAY_MUX_BLINK_EN
  localparam int unsigned FCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              colon_q, colon_d;

  // Colon half-period counted in whole frames
  always_comb begin
    fcnt_d  = fcnt_q;
    colon_d = colon_q;
    if (frame_end_c) begin
      if (fcnt_q == FCNT_W'(BLINK_FRAMES - 1)) begin
        fcnt_d  = '0;
        colon_d = ~colon_q;
      end else begin
        fcnt_d = fcnt_q + FCNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt_q  <= '0;
      colon_q <= 1'b1;
    end else begin
      fcnt_q  <= fcnt_d;
      colon_q <= colon_d;
    end
  end

  assign colon_on = colon_q;
`else
  assign colon_on = 1'b1;
`endif

endmodule

// File: tb/tb_display_mux_7seg.sv
// Directed self-checking bench for display_mux_7seg with SCAN_DIV=8, DEAD=2, BLINK_FRAMES=2.
// Edge k is the k-th rising clock edge after reset release; outputs are sampled 1 ns after it.
module tb_display_mux_7seg;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] dhour, uhour, dmin, umin;
  logic       blank_lz;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp, frame_done, err;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_n   = 0;

  logic [6:0] seg_tab [0:9] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                                7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};
  localparam logic [6:0] DASH = 7'b1000000;

  display_mux_7seg #(.SCAN_DIV(8), .DEAD(2), .BLINK_FRAMES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .dhour_i(dhour), .uhour_i(uhour), .dmin_i(dmin), .umin_i(umin),
    .blank_lz_i(blank_lz),
    .an_o(an), .seg_o(seg), .dp_o(dp), .frame_done_o(frame_done), .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", tag, got, exp, edge_n, $time);
    end
  endtask

  task automatic run_to(input int n);
    while (edge_n < n) begin
      @(posedge clk);
      #1;
      edge_n++;
    end
  endtask

  function automatic logic dp_exp(input int frame);
`ifdef DISPLAY_MUX_BLINK_EN
    return ((frame / 2) % 2) == 0;
`else
    return 1'b1;
`endif
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    dhour = 4'd1; uhour = 4'd2; dmin = 4'd3; umin = 4'd4; blank_lz = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_an", 32'(an), 32'hF);
    check("rst_seg", 32'(seg), 32'h0);
    check("rst_dp", 32'(dp), 32'h0);
    check("rst_fd", 32'(frame_done), 32'h0);
    check("rst_err", 32'(err), 32'h0);

    @(negedge clk);
    rst_n  = 1'b1;
    edge_n = 0;

    for (int e = 1; e <= 8; e++) begin
      run_to(e);
      if (e <= 2) begin
        check("s0_dead_an", 32'(an), 32'hF);
      end else begin
        check("s0_an", 32'(an), 32'h7);
        check("s0_seg", 32'(seg), 32'(seg_tab[1]));
      end
    end
    run_to(10);
    check("s1_dead_an", 32'(an), 32'hF);
    check("s1_dead_dp", 32'(dp), 32'h0);
    run_to(11);
    check("s1_an", 32'(an), 32'hB);
    check("s1_seg", 32'(seg), 32'(seg_tab[2]));
    check("f0_dp", 32'(dp), 32'(dp_exp(0)));
    umin = 4'd5;
    run_to(19);
    check("s2_dp_off", 32'(dp), 32'h0);
    run_to(27);
    check("s3_an", 32'(an), 32'hE);
    check("s3_seg_old", 32'(seg), 32'(seg_tab[4]));
    run_to(31);
    check("fd_early", 32'(frame_done), 32'h0);
    run_to(32);
    check("fd_pulse", 32'(frame_done), 32'h1);
    run_to(33);
    check("fd_drop", 32'(frame_done), 32'h0);
    run_to(43);
    check("f1_dp", 32'(dp), 32'(dp_exp(1)));
    run_to(59);
    check("s3_seg_new", 32'(seg), 32'(seg_tab[5]));
    run_to(64);
    check("fd_pulse2", 32'(frame_done), 32'h1);
    run_to(75);
    check("f2_dp", 32'(dp), 32'(dp_exp(2)));

    run_to(99);
    dhour = 4'd0; uhour = 4'd9; dmin = 4'd5; umin = 4'd9; blank_lz = 1'b1;
    run_to(107);
    check("f3_dp", 32'(dp), 32'(dp_exp(3)));
    run_to(131);
    check("blank_an", 32'(an), 32'hF);
    check("blank_seg", 32'(seg), 32'h0);
    run_to(139);
    check("b_s1_an", 32'(an), 32'hB);
    check("b_s1_seg", 32'(seg), 32'(seg_tab[9]));
    run_to(147);
    check("b_s2_an", 32'(an), 32'hD);
    check("b_s2_seg", 32'(seg), 32'(seg_tab[5]));
    check("b_err", 32'(err), 32'h0);

    dhour = 4'd2; uhour = 4'd4; blank_lz = 1'b0;
    run_to(160);
    check("err_pre", 32'(err), 32'h0);
    run_to(161);
    check("err_24", 32'(err), 32'h1);
    dhour = 4'd1; uhour = 4'd2; dmin = 4'd3; umin = 4'd4;
    run_to(200);
    check("err_sticky", 32'(err), 32'h1);

    uhour = 4'hC;
    run_to(235);
    check("dash_an", 32'(an), 32'hB);
    check("dash_seg", 32'(seg), 32'(DASH));
    run_to(245);
    check("mid_s2_an", 32'(an), 32'hD);
    check("mid_s2_seg", 32'(seg), 32'(seg_tab[3]));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_an", 32'(an), 32'hF);
    check("async_seg", 32'(seg), 32'h0);
    check("async_err", 32'(err), 32'h0);

    @(negedge clk);
    rst_n  = 1'b1;
    edge_n = 0;
    run_to(1);
    check("rr_e1_an", 32'(an), 32'hF);
    check("err_dash", 32'(err), 32'h1);
    run_to(2);
    check("rr_e2_an", 32'(an), 32'hF);
    run_to(3);
    check("rr_e3_an", 32'(an), 32'h7);
    check("rr_e3_seg", 32'(seg), 32'(seg_tab[1]));
    run_to(11);
    check("rr_dash", 32'(seg), 32'(DASH));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
